// File: rtl/writeback_queue.sv
// Circular writeback queue between execute and the register file, with pending-write hazard
// detection. Define WRITEBACK_QUEUE_FORWARD_EN to add youngest-match forwarding outputs.
module writeback_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_addr,
    input  logic [31:0]              in_data,
    input  logic                     wr_hold,
    output logic                     wr_ena,
    output logic [4:0]               wr_addr,
    output logic [31:0]              wr_data,
    input  logic [4:0]               rd_addr0,
    input  logic [4:0]               rd_addr1,
    output logic                     hazard0,
    output logic                     hazard1,
`ifdef WRITEBACK_QUEUE_FORWARD_EN
    output logic [31:0]              fwd_data0,
    output logic [31:0]              fwd_data1,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    logic [4:0]  addr_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];

    logic             push;
    logic             pop;
    logic [DEPTH-1:0] occupied;
    logic [DEPTH-1:0] match0;
    logic [DEPTH-1:0] match1;

    assign in_ready = (count_q < CntW'(DEPTH));
    // Zero-address requests are consumed but never stored.
    assign push     = in_valid && in_ready && (in_addr != 5'd0);
    assign pop      = wr_ena;

    assign wr_ena  = (count_q != '0) && !wr_hold;
    assign wr_addr = addr_mem[head_q];
    assign wr_data = data_mem[head_q];
    assign count   = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = tail_q + PtrW'(1);
        end
        if (pop) begin
            head_d = head_q + PtrW'(1);
        end
        count_d = count_q + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left unreset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_q] <= in_addr;
            data_mem[tail_q] <= in_data;
        end
    end

    // A slot is live when its distance from head is below count.
    always_comb begin
        occupied = '0;
        match0   = '0;
        match1   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            logic [PtrW-1:0] offset;
            offset      = PtrW'(i) - head_q;
            occupied[i] = ({1'b0, offset} < count_q);
            match0[i]   = occupied[i] && (addr_mem[i] == rd_addr0);
            match1[i]   = occupied[i] && (addr_mem[i] == rd_addr1);
        end
    end

    assign hazard0 = (rd_addr0 != 5'd0) && (|match0);
    assign hazard1 = (rd_addr1 != 5'd0) && (|match1);

`ifdef WRITEBACK_QUEUE_FORWARD_EN
    // Walk from head towards tail so the youngest matching entry wins.
    always_comb begin
        fwd_data0 = '0;
        fwd_data1 = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            logic [PtrW-1:0] idx;
            idx = head_q + PtrW'(k);
            if (match0[idx]) begin
                fwd_data0 = data_mem[idx];
            end
            if (match1[idx]) begin
                fwd_data1 = data_mem[idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed self-checking bench for writeback_queue (DEPTH 4); forwarding outputs are
// checked when WRITEBACK_QUEUE_FORWARD_EN is defined.
module tb_writeback_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        wr_hold;
    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr0;
    logic [4:0]  rd_addr1;
    logic        hazard0;
    logic        hazard1;
    logic [2:0]  count;
`ifdef WRITEBACK_QUEUE_FORWARD_EN
    logic [31:0] fwd_data0;
    logic [31:0] fwd_data1;
`endif

    int n_checks;
    int n_fail;

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .wr_hold  (wr_hold),
        .wr_ena   (wr_ena),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .hazard0  (hazard0),
        .hazard1  (hazard1),
`ifdef WRITEBACK_QUEUE_FORWARD_EN
        .fwd_data0(fwd_data0),
        .fwd_data1(fwd_data1),
`endif
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] wrap_addr(input int j);
        return 5'((j % 30) + 1);
    endfunction

    function automatic logic [31:0] wrap_data(input int j);
        return 32'hC000_0000 + 32'(j);
    endfunction

    task automatic test_reset();
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (wr_ena !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ena: got %b expected 0", wr_ena); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if ({hazard0, hazard1} !== 2'b00) begin n_fail++; $display("FAIL reset_hazard: got %b%b expected 00", hazard0, hazard1); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_addr = 5'd5; in_data = 32'hDEADBEEF; wr_hold = 1'b0;
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_pre_count: got %0d expected 0", count); end
        step();
        in_valid = 1'b0;
        #1;
        n_checks++; if (wr_ena !== 1'b1) begin n_fail++; $display("FAIL single_wr_ena: got %b expected 1", wr_ena); end
        n_checks++; if (wr_addr !== 5'd5) begin n_fail++; $display("FAIL single_wr_addr: got %0d expected 5", wr_addr); end
        n_checks++; if (wr_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_wr_data: got %h expected deadbeef", wr_data); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", count); end
        step();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_post_count: got %0d expected 0", count); end
        n_checks++; if (wr_ena !== 1'b0) begin n_fail++; $display("FAIL single_post_wr_ena: got %b expected 0", wr_ena); end
    endtask

    task automatic test_full();
        wr_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_addr = 5'(i); in_data = 32'hA0 + 32'(i);
            step();
        end
        in_addr = 5'd5; in_data = 32'hFF;
        #1;
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d expected 4", count); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
        n_checks++; if (wr_ena !== 1'b0) begin n_fail++; $display("FAIL full_hold_wr_ena: got %b expected 0", wr_ena); end
        step();
        in_valid = 1'b0;
        #1;
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_fifth_push: got count %0d expected 4", count); end
        wr_hold = 1'b0;
        #1;
        for (int i = 1; i <= 4; i++) begin
            n_checks++; if (wr_ena !== 1'b1) begin n_fail++; $display("FAIL full_drain_ena[%0d]: got %b expected 1", i, wr_ena); end
            n_checks++; if (wr_addr !== 5'(i)) begin n_fail++; $display("FAIL full_drain_addr[%0d]: got %0d expected %0d", i, wr_addr, i); end
            n_checks++; if (wr_data !== 32'hA0 + 32'(i)) begin n_fail++; $display("FAIL full_drain_data[%0d]: got %h expected %h", i, wr_data, 32'hA0 + 32'(i)); end
            step();
        end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL full_empty_count: got %0d expected 0", count); end
        n_checks++; if (wr_ena !== 1'b0) begin n_fail++; $display("FAIL full_empty_wr_ena: got %b expected 0", wr_ena); end
    endtask

    task automatic test_zero_addr();
        in_valid = 1'b1; in_addr = 5'd0; in_data = 32'h1234; wr_hold = 1'b0;
        step();
        in_valid = 1'b0;
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL zero_count: got %0d expected 0", count); end
        n_checks++; if (wr_ena !== 1'b0) begin n_fail++; $display("FAIL zero_wr_ena: got %b expected 0", wr_ena); end
        step();
        n_checks++; if (wr_ena !== 1'b0) begin n_fail++; $display("FAIL zero_wr_ena_later: got %b expected 0", wr_ena); end
    endtask

    task automatic test_hazard();
        wr_hold = 1'b1;
        in_valid = 1'b1; in_addr = 5'd7; in_data = 32'h11;
        step();
        in_data = 32'h22;
        step();
        in_valid = 1'b0; rd_addr0 = 5'd7; rd_addr1 = 5'd0;
        #1;
        n_checks++; if (hazard0 !== 1'b1) begin n_fail++; $display("FAIL hazard0_match: got %b expected 1", hazard0); end
        n_checks++; if (hazard1 !== 1'b0) begin n_fail++; $display("FAIL hazard1_zero: got %b expected 0", hazard1); end
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL hazard_count: got %0d expected 2", count); end
`ifdef WRITEBACK_QUEUE_FORWARD_EN
        n_checks++; if (fwd_data0 !== 32'h22) begin n_fail++; $display("FAIL fwd0_youngest: got %h expected 22", fwd_data0); end
`endif
        // A same-cycle request must not raise a hazard; dropped before the edge.
        rd_addr1 = 5'd9; in_valid = 1'b1; in_addr = 5'd9; in_data = 32'h99;
        #1;
        n_checks++; if (hazard1 !== 1'b0) begin n_fail++; $display("FAIL hazard1_same_cycle: got %b expected 0", hazard1); end
        in_valid = 1'b0; rd_addr1 = 5'd7;
        #1;
        n_checks++; if (hazard1 !== 1'b1) begin n_fail++; $display("FAIL hazard1_match: got %b expected 1", hazard1); end
`ifdef WRITEBACK_QUEUE_FORWARD_EN
        n_checks++; if (fwd_data1 !== 32'h22) begin n_fail++; $display("FAIL fwd1_youngest: got %h expected 22", fwd_data1); end
`endif
        wr_hold = 1'b0;
        #1;
        n_checks++; if (wr_data !== 32'h11) begin n_fail++; $display("FAIL dup_order_first: got %h expected 11", wr_data); end
        step();
        n_checks++; if (wr_data !== 32'h22) begin n_fail++; $display("FAIL dup_order_second: got %h expected 22", wr_data); end
        n_checks++; if (hazard0 !== 1'b1) begin n_fail++; $display("FAIL hazard0_head_only: got %b expected 1", hazard0); end
        step();
        n_checks++; if (hazard0 !== 1'b0) begin n_fail++; $display("FAIL hazard0_drained: got %b expected 0", hazard0); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL hazard_drained_count: got %0d expected 0", count); end
        rd_addr0 = 5'd0; rd_addr1 = 5'd0;
    endtask

    task automatic test_wrap();
        wr_hold = 1'b1;
        in_valid = 1'b1; in_addr = wrap_addr(0); in_data = wrap_data(0);
        step();
        in_addr = wrap_addr(1); in_data = wrap_data(1);
        step();
        wr_hold = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_addr = wrap_addr(i + 2); in_data = wrap_data(i + 2);
            #1;
            n_checks++; if (wr_ena !== 1'b1) begin n_fail++; $display("FAIL wrap_ena[%0d]: got %b expected 1", i, wr_ena); end
            n_checks++; if (wr_addr !== wrap_addr(i)) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, wr_addr, wrap_addr(i)); end
            n_checks++; if (wr_data !== wrap_data(i)) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, wr_data, wrap_data(i)); end
            n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d expected 2", i, count); end
            step();
        end
        in_valid = 1'b0;
        for (int i = 10; i < 12; i++) begin
            #1;
            n_checks++; if (wr_data !== wrap_data(i)) begin n_fail++; $display("FAIL wrap_tail_data[%0d]: got %h expected %h", i, wr_data, wrap_data(i)); end
            step();
        end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL wrap_final_count: got %0d expected 0", count); end
    endtask

    task automatic test_reset_mid();
        wr_hold = 1'b1;
        in_valid = 1'b1; in_addr = 5'd3; in_data = 32'h3;
        step();
        in_addr = 5'd4; in_data = 32'h4;
        step();
        in_addr = 5'd6; in_data = 32'h6;
        step();
        in_valid = 1'b0; rd_addr0 = 5'd4; wr_hold = 1'b0;
        #1;
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL rmid_pre_count: got %0d expected 3", count); end
        n_checks++; if (wr_ena !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_wr_ena: got %b expected 1", wr_ena); end
        n_checks++; if (hazard0 !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_hazard0: got %b expected 1", hazard0); end
        rst = 1'b0;
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rmid_count: got %0d expected 0", count); end
        n_checks++; if (wr_ena !== 1'b0) begin n_fail++; $display("FAIL rmid_wr_ena: got %b expected 0", wr_ena); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (hazard0 !== 1'b0) begin n_fail++; $display("FAIL rmid_hazard0: got %b expected 0", hazard0); end
        step();
        in_valid = 1'b1; in_addr = 5'd12; in_data = 32'h5A5A;
        #2 rst = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL rel_first_count: got %0d expected 1", count); end
        n_checks++; if (wr_ena !== 1'b1) begin n_fail++; $display("FAIL rel_first_wr_ena: got %b expected 1", wr_ena); end
        n_checks++; if (wr_addr !== 5'd12) begin n_fail++; $display("FAIL rel_first_wr_addr: got %0d expected 12", wr_addr); end
        n_checks++; if (wr_data !== 32'h5A5A) begin n_fail++; $display("FAIL rel_first_wr_data: got %h expected 5a5a", wr_data); end
        n_checks++; if (hazard0 !== 1'b0) begin n_fail++; $display("FAIL rel_dropped_hazard0: got %b expected 0", hazard0); end
        step();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rel_final_count: got %0d expected 0", count); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_addr  = 5'd0;
        in_data  = 32'd0;
        wr_hold  = 1'b0;
        rd_addr0 = 5'd0;
        rd_addr1 = 5'd0;
        test_reset();
        step();
        test_single();
        test_full();
        test_zero_addr();
        test_hazard();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, pending-write entries; power of two, >= 2.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  writeback request present.
REQ-005 SHALL have port in_ready  output  1  queue can accept a request this cycle.
REQ-006 SHALL have port in_addr  input  5  destination register index.
REQ-007 SHALL have port in_data  input  32  destination register value.
REQ-008 SHALL have port wr_hold  input  1  suppresses draining this cycle.
REQ-009 SHALL have port wr_ena  output  1  register-file write enable.
REQ-010 SHALL have port wr_addr  output  5  register-file write address.
REQ-011 SHALL have port wr_data  output  32  register-file write data.
REQ-012 SHALL have ports rd_addr0, rd_addr1  input  5 each  operand addresses to check against pending writes.
REQ-013 SHALL have ports hazard0, hazard1  output  1 each  matching operand has a pending write.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  number of stored entries.

Function
REQ-015 SHALL store entries in a circular FIFO with head/tail pointers wrapping from DEPTH-1 to 0.
REQ-016 SHALL drive in_ready = (count < DEPTH), combinationally, independent of the same-cycle drain; no pass-through when full.
REQ-017 SHALL accept a request on a rising edge where in_valid && in_ready.
REQ-018 SHALL discard an accepted request with in_addr == 0: consumed, not stored, count unchanged.
REQ-019 SHALL drive wr_ena = (count != 0) && !wr_hold, with wr_addr/wr_data taken combinationally from the head entry.
REQ-020 SHALL pop the head on every rising edge where wr_ena == 1; the register file always accepts.
REQ-021 SHALL present an entry accepted at edge N on wr_* in the following cycle; with wr_hold low it is written at edge N+1 (1-cycle latency, 1 write/cycle throughput).
REQ-022 SHALL handle simultaneous push and pop in one edge: count unchanged, both pointers advance.
REQ-023 SHALL drive wr_addr/wr_data as don't-care when wr_ena == 0; the bench checks them only while wr_ena == 1.
REQ-024 SHALL assert hazardK when rd_addrK != 0 and any stored entry, head included, has addr == rd_addrK; same-cycle in_* requests are excluded.
REQ-025 SHALL drive hazardK = 0 whenever rd_addrK == 0.
REQ-026 SHALL drain entries with duplicate addresses in arrival order; no merging.

Reset
REQ-027 SHALL, while rst is low, force count = 0, head = tail = 0, wr_ena = 0, hazard0 = hazard1 = 0 and in_ready = 1, asynchronously.
REQ-028 SHALL drop all queued entries on reset mid-operation; storage contents are not reset.
REQ-029 SHALL accept the first request at the first rising edge after rst deasserts.

Configuration
REQ-030 SHALL, with macro WRITEBACK_QUEUE_FORWARD_EN defined, add outputs fwd_data0, fwd_data1 (32 each), each equal to in_data of the youngest stored entry matching rd_addrK, valid when hazardK == 1.
REQ-031 SHALL, without WRITEBACK_QUEUE_FORWARD_EN, omit fwd_data0/fwd_data1 and the youngest-match logic; all other behaviour is identical.

Verification
REQ-032 SHALL cover: push addr 5 data 0xDEADBEEF, wr_hold = 0 -> next cycle wr_ena = 1, wr_addr = 5, wr_data = 0xDEADBEEF; count returns to 0 after the next edge.
REQ-033 SHALL cover: wr_hold = 1, push addrs 1..4 (DEPTH 4) -> count = 4, in_ready = 0, a 5th push is not accepted; release wr_hold -> writes 1,2,3,4 on 4 consecutive cycles.
REQ-034 SHALL cover: push addr 0 data 0x1234 -> count stays 0, wr_ena never asserts.
REQ-035 SHALL cover: hold; push (7, 0x11) then (7, 0x22); rd_addr0 = 7, rd_addr1 = 0 -> hazard0 = 1, hazard1 = 0; with the macro fwd_data0 = 0x22.
REQ-036 SHALL cover: pointer wrap over 10 push/pop pairs at count = 2 -> data drains in order, count constant.
REQ-037 SHALL cover: rst low with count = 3 -> count = 0, wr_ena = 0, in_ready = 1 immediately, before the next clock edge.
